// File: rtl/mpu_pkg.sv
// mpu_pkg: shared definitions for the MPU6050 accel path.
//   state_t      - frame FSM encodings
//   FRAME_BYTES  - bytes per accel burst (XH XL YH YL ZH ZL)
//   MPU_*        - MPU6050 device/register constants shared with the I2C reader
package mpu_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_POLL = 3'd1,
        REQ       = 3'd2,
        WAIT_BYTE = 3'd3,
        EVAL      = 3'd4
    } state_t;

    localparam int unsigned FRAME_BYTES = 6;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned DIFF_W      = SAMPLE_W + 1;
    localparam int unsigned SUM_W       = DIFF_W + 2;
    localparam int unsigned RUN_W       = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    localparam logic [6:0] MPU_I2C_ADDR      = 7'h68;
    localparam logic [7:0] MPU_REG_ACCEL_XH  = 8'h3B;
    localparam logic [7:0] MPU_REG_PWR_MGMT1 = 8'h6B;
    localparam logic [7:0] MPU_REG_WHO_AM_I  = 8'h75;

endpackage

// File: rtl/mpu_abs_diff.sv
// mpu_abs_diff: |a - b| of two signed 16-bit samples, full 17-bit magnitude.
//   a, b : signed 16-bit inputs
//   d    : unsigned 17-bit absolute difference (0..65535)
module mpu_abs_diff
    import mpu_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [SAMPLE_W-1:0] b,
    output logic        [DIFF_W-1:0]   d
);

    // Sign-extend before subtracting so the difference cannot overflow.
    logic signed [DIFF_W-1:0] diff;

    assign diff = {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
    assign d    = diff[DIFF_W-1] ? DIFF_W'(-diff) : DIFF_W'(diff);

endmodule

// File: rtl/mpu_motion_frame.sv
// mpu_motion_frame: paces MPU6050 accel reads, assembles X/Y/Z samples and
// flags shake events.
//   clk, rst_n          clock, async active-low reset
//   enable              polling active when 1
//   byte_in, byte_valid reader data and level-valid
//   rd_start            one-cycle request for the next byte
//   accel_x/y/z         signed samples, updated together
//   sample_valid        one-cycle pulse when samples update
//   shake               one-cycle shake-event pulse
//   frame_err           one-cycle pulse on byte timeout
//   busy                high outside IDLE/WAIT_POLL
module mpu_motion_frame
    import mpu_pkg::*;
#(
    parameter int unsigned POLL_CYCLES    = 2_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000,
    parameter int unsigned SHAKE_THRESH   = 8000,
    parameter int unsigned SHAKE_COUNT    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid,
    output logic                       rd_start,
    output logic signed [SAMPLE_W-1:0] accel_x,
    output logic signed [SAMPLE_W-1:0] accel_y,
    output logic signed [SAMPLE_W-1:0] accel_z,
    output logic                       sample_valid,
    output logic                       shake,
    output logic                       frame_err,
    output logic                       busy
);

    localparam int unsigned PCNT_W = $clog2(POLL_CYCLES);
    localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t              state;
    logic [PCNT_W-1:0]   poll_cnt;
    logic [TCNT_W-1:0]   tout_cnt;
    logic [IDX_W-1:0]    idx;
    logic [7:0]          slot [FRAME_BYTES];
    logic                vld_q;
    logic                edge_q;
    logic [7:0]          byte_q;
    logic                have_prev;
    logic [RUN_W-1:0]    run_cnt;
    logic                shake_pend;
    logic signed [SAMPLE_W-1:0] prev_x, prev_y, prev_z;

    logic signed [SAMPLE_W-1:0] new_x, new_y, new_z;
    logic [DIFF_W-1:0]          dx, dy, dz;
    logic [SUM_W-1:0]           diff_sum;
    logic                       over_thresh;
    logic [RUN_W-1:0]           run_inc;

    // Candidate samples straight from the collected burst (valid in EVAL).
    assign new_x = $signed({slot[0], slot[1]});
    assign new_y = $signed({slot[2], slot[3]});
    assign new_z = $signed({slot[4], slot[5]});

    mpu_abs_diff u_dx (.a(new_x), .b(prev_x), .d(dx));
    mpu_abs_diff u_dy (.a(new_y), .b(prev_y), .d(dy));
    mpu_abs_diff u_dz (.a(new_z), .b(prev_z), .d(dz));

    assign diff_sum    = SUM_W'(dx) + SUM_W'(dy) + SUM_W'(dz);
    assign over_thresh = diff_sum > SUM_W'(SHAKE_THRESH);
    assign run_inc     = run_cnt + RUN_W'(1);

    // Frame FSM with registered outputs; byte_valid edge is detected one
    // register late and its data captured alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            poll_cnt     <= '0;
            tout_cnt     <= '0;
            idx          <= '0;
            for (int i = 0; i < FRAME_BYTES; i++) slot[i] <= '0;
            vld_q        <= 1'b0;
            edge_q       <= 1'b0;
            byte_q       <= '0;
            have_prev    <= 1'b0;
            run_cnt      <= '0;
            shake_pend   <= 1'b0;
            prev_x       <= '0;
            prev_y       <= '0;
            prev_z       <= '0;
            rd_start     <= 1'b0;
            accel_x      <= '0;
            accel_y      <= '0;
            accel_z      <= '0;
            sample_valid <= 1'b0;
            shake        <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rd_start     <= 1'b0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            shake        <= shake_pend;
            shake_pend   <= 1'b0;
            vld_q        <= byte_valid;
            edge_q       <= byte_valid & ~vld_q;
            byte_q       <= byte_in;

            case (state)
                IDLE: begin
                    idx      <= '0;
                    poll_cnt <= '0;
                    busy     <= 1'b0;
                    if (enable) state <= WAIT_POLL;
                end

                WAIT_POLL: begin
                    if (!enable) begin
                        state    <= IDLE;
                        poll_cnt <= '0;
                        idx      <= '0;
                    end else if (poll_cnt == PCNT_W'(POLL_CYCLES - 1)) begin
                        poll_cnt <= '0;
                        state    <= REQ;
                        busy     <= 1'b1;
                    end else begin
                        poll_cnt <= poll_cnt + PCNT_W'(1);
                    end
                end

                REQ: begin
                    if (!enable) begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        rd_start <= 1'b1;
                        tout_cnt <= '0;
                        state    <= WAIT_BYTE;
                    end
                end

                WAIT_BYTE: begin
                    if (!enable) begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else if (edge_q) begin
                        // Edge wins over a coincident timeout.
                        slot[idx] <= byte_q;
                        if (idx == LAST_IDX) begin
                            state <= EVAL;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= REQ;
                        end
                    end else if (tout_cnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        frame_err <= 1'b1;
                        idx       <= '0;
                        state     <= WAIT_POLL;
                        busy      <= 1'b0;
                    end else begin
                        tout_cnt <= tout_cnt + TCNT_W'(1);
                    end
                end

                EVAL: begin
                    accel_x      <= new_x;
                    accel_y      <= new_y;
                    accel_z      <= new_z;
                    sample_valid <= 1'b1;
                    prev_x       <= new_x;
                    prev_y       <= new_y;
                    prev_z       <= new_z;
                    idx          <= '0;
                    busy         <= 1'b0;
                    state        <= enable ? WAIT_POLL : IDLE;
                    // The first frame after reset only seeds the history.
                    if (!have_prev) begin
                        have_prev <= 1'b1;
                    end else if (over_thresh) begin
                        if (run_inc == RUN_W'(SHAKE_COUNT)) begin
                            shake_pend <= 1'b1;
                            run_cnt    <= '0;
                        end else begin
                            run_cnt <= run_inc;
                        end
                    end else begin
                        run_cnt <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_motion_frame.sv
// tb_mpu_motion_frame: directed bench for mpu_motion_frame with a simple
// reader model (byte_valid raised a few cycles after each rd_start).
module tb_mpu_motion_frame;

    localparam int unsigned POLL    = 64;
    localparam int unsigned TOUT    = 40;
    localparam int unsigned THRESH  = 8000;
    localparam int unsigned SCOUNT  = 3;
    localparam int          WAIT_MAX = POLL + TOUT + 40;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        rd_start;
    logic [15:0] accel_x, accel_y, accel_z;
    logic        sample_valid, shake, frame_err, busy;

    int n_vec = 0;
    int n_err = 0;

    int cnt_rd = 0, cnt_sv = 0, cnt_shake = 0, cnt_ferr = 0;
    int shake_sv_idx = 0;
    bit shake_lag_ok = 0;
    bit prev_sv = 0;

    mpu_motion_frame #(
        .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TOUT),
        .SHAKE_THRESH(THRESH), .SHAKE_COUNT(SCOUNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .byte_in(byte_in), .byte_valid(byte_valid), .rd_start(rd_start),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .sample_valid(sample_valid), .shake(shake), .frame_err(frame_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (rd_start) cnt_rd++;
        if (sample_valid) cnt_sv++;
        if (frame_err) cnt_ferr++;
        if (shake) begin
            cnt_shake++;
            shake_sv_idx = cnt_sv;
            shake_lag_ok = prev_sv;
        end
        prev_sv = sample_valid;
    end

    task automatic clear_counts();
        @(posedge clk); #1;
        cnt_rd = 0; cnt_sv = 0; cnt_shake = 0; cnt_ferr = 0;
        shake_sv_idx = 0; shake_lag_ok = 0;
    endtask

    task automatic wait_rd(output bit ok);
        ok = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            if (rd_start) begin ok = 1; break; end
        end
    endtask

    task automatic serve_byte(input logic [7:0] b, input int dly, output bit ok);
        wait_rd(ok);
        if (!ok) return;
        repeat (dly) @(posedge clk);
        #1; byte_in = b; byte_valid = 1'b1;
        @(posedge clk); #1; byte_valid = 1'b0;
    endtask

    // Serves a whole burst; lat_ok reports sample_valid exactly 2 clk after the last rise.
    task automatic serve_frame(input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] z, output bit ok, output bit lat_ok);
        logic [7:0] b [6];
        bit sv0, sv1, sv2;
        b[0] = x[15:8]; b[1] = x[7:0];
        b[2] = y[15:8]; b[3] = y[7:0];
        b[4] = z[15:8]; b[5] = z[7:0];
        lat_ok = 0;
        for (int i = 0; i < 6; i++) begin
            serve_byte(b[i], (i % 4) + 1, ok);
            if (!ok) return;
        end
        @(negedge clk); sv0 = sample_valid;
        @(negedge clk); sv1 = sample_valid;
        @(negedge clk); sv2 = sample_valid;
        lat_ok = !sv0 && !sv1 && sv2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; byte_in = '0; byte_valid = 1'b0;
        #2;
        n_vec++;
        if ({rd_start, sample_valid, shake, frame_err, busy} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl got=%b want=00000",
                              {rd_start, sample_valid, shake, frame_err, busy});
        end
        n_vec++;
        if ({accel_x, accel_y, accel_z} !== 48'h0) begin
            n_err++; $display("FAIL reset_accel got=%h want=0", {accel_x, accel_y, accel_z});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        bit ok, lat;
        enable = 1'b1;
        clear_counts();
        serve_frame(16'h0100, 16'hFF00, 16'h4000, ok, lat);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL basic_rdstart got=timeout want=6 requests"); end
        n_vec++;
        if (lat !== 1'b1) begin n_err++; $display("FAIL basic_latency got=%b want=1", lat); end
        n_vec++;
        if (accel_x !== 16'h0100) begin n_err++; $display("FAIL basic_x got=%0d want=256", $signed(accel_x)); end
        n_vec++;
        if (accel_y !== 16'hFF00) begin n_err++; $display("FAIL basic_y got=%0d want=-256", $signed(accel_y)); end
        n_vec++;
        if (accel_z !== 16'h4000) begin n_err++; $display("FAIL basic_z got=%0d want=16384", $signed(accel_z)); end
        repeat (4) @(negedge clk);
        n_vec++;
        if (cnt_sv !== 1) begin n_err++; $display("FAIL basic_sv_count got=%0d want=1", cnt_sv); end
        n_vec++;
        if (cnt_rd !== 6) begin n_err++; $display("FAIL basic_rd_count got=%0d want=6", cnt_rd); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_idle got=%b want=0", busy); end
        n_vec++;
        if (cnt_shake !== 0) begin n_err++; $display("FAIL basic_no_shake got=%0d want=0", cnt_shake); end
    endtask

    task automatic test_shake();
        bit ok, lat;
        logic [15:0] zs [6];
        zs[0] = 16'h4000; zs[1] = 16'hC000; zs[2] = 16'h4000;
        zs[3] = 16'hC000; zs[4] = 16'hC000; zs[5] = 16'hC000;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        clear_counts();
        for (int f = 0; f < 6; f++) begin
            serve_frame(16'h0000, 16'h0000, zs[f], ok, lat);
            n_vec++;
            if (!ok || accel_z !== zs[f]) begin
                n_err++; $display("FAIL shake_frame%0d_z got=%h want=%h ok=%b", f, accel_z, zs[f], ok);
            end
            repeat (3) @(negedge clk);
            if (f == 2) begin
                n_vec++;
                if (cnt_shake !== 0) begin n_err++; $display("FAIL shake_early got=%0d want=0", cnt_shake); end
            end
            if (f == 3) begin
                n_vec++;
                if (cnt_shake !== 1 || shake_sv_idx !== 4) begin
                    n_err++; $display("FAIL shake_on_4th got=%0d@frame%0d want=1@frame4", cnt_shake, shake_sv_idx);
                end
                n_vec++;
                if (shake_lag_ok !== 1'b1) begin n_err++; $display("FAIL shake_after_sv got=%b want=1", shake_lag_ok); end
            end
        end
        n_vec++;
        if (cnt_shake !== 1) begin n_err++; $display("FAIL shake_static got=%0d want=1", cnt_shake); end
    endtask

    task automatic test_timeout();
        bit ok, lat;
        int cyc;
        bit seen;
        clear_counts();
        serve_byte(8'h11, 2, ok);
        if (ok) serve_byte(8'h22, 3, ok);
        if (ok) wait_rd(ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL tout_third_req got=timeout want=rd_start"); end
        cyc = 0; seen = 0;
        for (int i = 0; i < TOUT + 20; i++) begin
            @(negedge clk); cyc++;
            if (frame_err) begin seen = 1; break; end
        end
        n_vec++;
        if (!seen || cyc != TOUT) begin
            n_err++; $display("FAIL tout_frame_err got=%0d cycles seen=%b want=%0d", cyc, seen, TOUT);
        end
        n_vec++;
        if ({accel_x, accel_y, accel_z} !== {16'h0000, 16'h0000, 16'hC000} || cnt_sv != 0) begin
            n_err++; $display("FAIL tout_outputs_kept got=%h sv=%0d want=00000000c000 sv=0",
                              {accel_x, accel_y, accel_z}, cnt_sv);
        end
        serve_frame(16'h1234, 16'h0000, 16'hC000, ok, lat);
        n_vec++;
        if (!ok || !lat || accel_x !== 16'h1234) begin
            n_err++; $display("FAIL tout_recover got=%h ok=%b lat=%b want=1234", accel_x, ok, lat);
        end
        n_vec++;
        if (cnt_ferr !== 1) begin n_err++; $display("FAIL tout_err_count got=%0d want=1", cnt_ferr); end
    endtask

    task automatic test_held_valid();
        bit ok, seen;
        clear_counts();
        wait_rd(ok);
        repeat (2) @(posedge clk);
        #1; byte_in = 8'h55; byte_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 3 * TOUT + 20; i++) begin
            @(negedge clk);
            if (frame_err) begin seen = 1; break; end
        end
        n_vec++;
        if (!ok || !seen) begin n_err++; $display("FAIL held_frame_err got=%b want=1", seen); end
        n_vec++;
        if (cnt_rd !== 2) begin n_err++; $display("FAIL held_rd_count got=%0d want=2", cnt_rd); end
        n_vec++;
        if (accel_x !== 16'h1234 || cnt_sv !== 0) begin
            n_err++; $display("FAIL held_outputs_kept got=%h sv=%0d want=1234 sv=0", accel_x, cnt_sv);
        end
        @(posedge clk); #1 byte_valid = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit ok, lat;
        clear_counts();
        serve_byte(8'hAA, 1, ok);
        if (ok) serve_byte(8'hBB, 2, ok);
        if (ok) wait_rd(ok);
        n_vec++;
        if (!ok || busy !== 1'b1) begin n_err++; $display("FAIL drop_busy_before got=%b want=1", busy); end
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy_after got=%b want=0", busy); end
        repeat (TOUT + 10) @(negedge clk);
        n_vec++;
        if (cnt_ferr !== 0 || cnt_sv !== 0 || cnt_rd !== 3 || busy !== 1'b0) begin
            n_err++; $display("FAIL drop_quiet got=ferr%0d sv%0d rd%0d busy%b want=ferr0 sv0 rd3 busy0",
                              cnt_ferr, cnt_sv, cnt_rd, busy);
        end
        @(posedge clk); #1 enable = 1'b1;
        clear_counts();
        serve_frame(16'hFFFE, 16'h7FFF, 16'h8000, ok, lat);
        n_vec++;
        if (!ok || {accel_x, accel_y, accel_z} !== {16'hFFFE, 16'h7FFF, 16'h8000}) begin
            n_err++; $display("FAIL drop_refresh got=%h ok=%b want=fffe7fff8000", {accel_x, accel_y, accel_z}, ok);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (cnt_rd !== 6 || cnt_shake !== 0) begin
            n_err++; $display("FAIL drop_refresh_counts got=rd%0d shake%0d want=rd6 shake0", cnt_rd, cnt_shake);
        end
    endtask

    task automatic test_async_reset();
        bit ok, lat;
        logic [15:0] zs [3];
        zs[0] = 16'h4000; zs[1] = 16'hC000; zs[2] = 16'h4000;
        serve_byte(8'h01, 1, ok);
        if (ok) serve_byte(8'h02, 1, ok);
        if (ok) serve_byte(8'h03, 1, ok);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({accel_x, accel_y, accel_z} !== 48'h0 ||
            {rd_start, sample_valid, shake, frame_err, busy} !== 5'b0) begin
            n_err++; $display("FAIL areset_outputs got=%h/%b want=0/00000",
                              {accel_x, accel_y, accel_z}, {rd_start, sample_valid, shake, frame_err, busy});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        clear_counts();
        for (int f = 0; f < 3; f++) begin
            serve_frame(16'h0000, 16'h0000, zs[f], ok, lat);
            n_vec++;
            if (!ok || !lat || accel_z !== zs[f]) begin
                n_err++; $display("FAIL areset_frame%0d got=%h ok=%b lat=%b want=%h", f, accel_z, ok, lat, zs[f]);
            end
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (cnt_shake !== 0 || cnt_sv !== 3) begin
            n_err++; $display("FAIL areset_no_compare got=shake%0d sv%0d want=shake0 sv3", cnt_shake, cnt_sv);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_shake();
        test_timeout();
        test_held_valid();
        test_enable_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
